// File: rtl/sub86_mem_arb.sv
// sub86_mem_arb: serializes sub86 core steps (fetch, optional data access,
// CE pulse) onto one single-port synchronous RAM and interleaves host/debug
// word transactions between core steps with round-robin priority.
module sub86_mem_arb #(
    parameter int AW           = 16,
    parameter bit ALWAYS_DREAD = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    // core side
    input  logic [31:0]   IA,
    output logic [15:0]   ID,
    input  logic [31:0]   A,
    input  logic [31:0]   Q,
    input  logic          WEN,
    input  logic          RD,
    input  logic [1:0]    BEN,
    output logic [31:0]   D,
    output logic          CE,
    // host side
    input  logic          HREQ,
    input  logic          HWE,
    input  logic [31:0]   HADDR,
    input  logic [31:0]   HWDATA,
    output logic [31:0]   HRDATA,
    output logic          HACK,
    // RAM side
    output logic [AW-1:0] MADDR,
    output logic [31:0]   MWDATA,
    output logic          MWE,
    output logic [3:0]    MBE,
    input  logic [31:0]   MRDATA
);

    typedef enum logic [3:0] {
        S_ARB,
        S_IF,
        S_IW,
        S_DA,
        S_DW,
        S_STEP,
        S_HACC,
        S_HW,
        S_HDONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] id_q, id_d;
    logic [31:0] d_q, d_d;
    logic [31:0] hrdata_q, hrdata_d;
    logic        ce_q, ce_d;
    logic        hack_q, hack_d;
    logic        last_host_q, last_host_d;   // 1 = host was granted last

    logic [3:0]  size_mask;
    logic [4:0]  data_shift;

    // Address bits above the RAM and the host byte offset are don't-cares.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IA[31:AW+2], IA[0], A[31:AW+2], HADDR[31:AW+2], HADDR[1:0]};

    // Byte-lane pattern for the core access size, before alignment to A[1:0].
    always_comb begin
        unique case (BEN)
            2'b01:   size_mask = 4'b1111;
            2'b11:   size_mask = 4'b0011;
            default: size_mask = 4'b0001;
        endcase
        data_shift = {A[1:0], 3'b000};
    end

    // RAM command decoded from the registered state, so the data phase sees
    // WEN/RD/A as the core produces them from the ID captured one cycle earlier.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        MADDR  = '0;
        MWDATA = '0;
        MWE    = 1'b0;
        MBE    = 4'b0000;
        unique case (state_q)
            S_IF: begin
                MADDR = IA[AW+1:2];
            end
            S_DA: begin
                MADDR = A[AW+1:2];
                if (!WEN) begin
                    MWE    = 1'b1;
                    MWDATA = Q << data_shift;
                    // Lanes pushed past bit 3 fall off: misaligned crossings truncate.
                    MBE    = size_mask << A[1:0];
                end
            end
            S_HACC: begin
                MADDR  = HADDR[AW+1:2];
                MWE    = HWE;
                MWDATA = HWDATA;
                MBE    = HWE ? 4'b1111 : 4'b0000;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output computation for the step/host sequencer.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        d_d         = d_q;
        hrdata_d    = hrdata_q;
        ce_d        = 1'b0;
        hack_d      = 1'b0;
        last_host_d = last_host_q;
        unique case (state_q)
            S_ARB: begin
                if (HREQ && !last_host_q) state_d = S_HACC;
                else                      state_d = S_IF;
            end
            S_IF: begin
                state_d = S_IW;
            end
            S_IW: begin
                id_d    = IA[1] ? MRDATA[31:16] : MRDATA[15:0];
                state_d = S_DA;
            end
            S_DA: begin
                if (WEN && (RD || ALWAYS_DREAD)) begin
                    state_d = S_DW;
                end else begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end
            end
            S_DW: begin
                d_d     = MRDATA >> data_shift;
                state_d = S_STEP;
                ce_d    = 1'b1;
            end
            S_STEP: begin
                last_host_d = 1'b0;
                state_d     = S_ARB;
            end
            S_HACC: begin
                if (HWE) begin
                    hack_d  = 1'b1;
                    state_d = S_HDONE;
                end else begin
                    state_d = S_HW;
                end
            end
            S_HW: begin
                hrdata_d = MRDATA;
                hack_d   = 1'b1;
                state_d  = S_HDONE;
            end
            S_HDONE: begin
                last_host_d = 1'b1;
                state_d     = S_ARB;
            end
            default: state_d = S_ARB;
        endcase
    end

    // Sequencer state and registered outputs; reset hands the first grant to the core.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_ARB;
            id_q        <= '0;
            d_q         <= '0;
            hrdata_q    <= '0;
            ce_q        <= 1'b0;
            hack_q      <= 1'b0;
            last_host_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            id_q        <= id_d;
            d_q         <= d_d;
            hrdata_q    <= hrdata_d;
            ce_q        <= ce_d;
            hack_q      <= hack_d;
            last_host_q <= last_host_d;
        end
    end

    assign ID     = id_q;
    assign D      = d_q;
    assign HRDATA = hrdata_q;
    assign CE     = ce_q;
    assign HACK   = hack_q;

endmodule
